way_fill_writer: RTL

- Write-side counterpart of the way-select read mux.
- Accepts a cache-line refill from the memory side as a stream of narrow beats and assembles the full line in an internal buffer.
- Then presents the line to all data ways, with a one-hot write enable that strobes exactly the selected way for one cycle.
- Sits between the refill/miss handler and the per-way data arrays of the 4-way set-associative cache.

---
 rtl/cache_pkg.sv | 19 +
 rtl/way_fill_writer.sv | 115 +++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way set-associative cache data path:
// default geometry, refill FSM states and the one-hot select check.
package cache_pkg;

    localparam int LINE_SIZE_BYTES = 32;
    localparam int WAYS            = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } fill_state_t;

    // True when exactly one bit is set; narrower selects are zero-extended.
    function automatic logic onehot_valid(input logic [31:0] i_vec);
        return (i_vec != 32'd0) && ((i_vec & (i_vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/way_fill_writer.sv
// Assembles a refill line from narrow beats, then strobes it for one cycle
// into the selected data way.
module way_fill_writer #(
    parameter int  LINE_SIZE_BYTES = cache_pkg::LINE_SIZE_BYTES,
    parameter int  WAYS            = cache_pkg::WAYS,
    parameter int  BEAT_BYTES      = 4,
    parameter int  SETS            = 64,
    localparam int IDX_W           = $clog2(SETS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_fill_start,
    input  logic [WAYS-1:0]              i_way_sel,
    input  logic [IDX_W-1:0]             i_index,
    input  logic                         i_abort,
    input  logic                         i_beat_valid,
    input  logic [BEAT_BYTES*8-1:0]      i_beat_data,
    output logic                         o_beat_ready,
    output logic [WAYS-1:0]              o_wr_en,
    output logic [IDX_W-1:0]             o_wr_index,
    output logic [LINE_SIZE_BYTES*8-1:0] o_wr_line,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);
    import cache_pkg::*;

    localparam int LINE_W = LINE_SIZE_BYTES * 8;
    localparam int BEAT_W = BEAT_BYTES * 8;
    localparam int BEATS  = LINE_SIZE_BYTES / BEAT_BYTES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fill_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_buf;
    logic [LINE_W-1:0] r_wr_line;
    logic [WAYS-1:0]   r_sel;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  r_wr_index;
    logic              r_err;

    logic              w_accept;
    logic              w_last;
    logic [LINE_W-1:0] w_line_next;

    // Abort gates ready so a beat offered in the abort cycle is never consumed.
    assign o_beat_ready = (r_state == COLLECT) && !i_abort;
    assign w_accept     = o_beat_ready && i_beat_valid;
    assign w_last       = w_accept && (r_cnt == LAST_BEAT);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_line_next = r_buf;
        for (int k = 0; k < BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_line_next[k*BEAT_W +: BEAT_W] = i_beat_data;
            end
        end
    end

    // NOTE: the line buffer is a flop array, not a RAM, so it takes a reset value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_wr_line  <= '0;
            r_sel      <= '0;
            r_index    <= '0;
            r_wr_index <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_fill_start) begin
                        if (onehot_valid(32'(i_way_sel))) begin
                            r_sel   <= i_way_sel;
                            r_index <= i_index;
                            r_cnt   <= '0;
                            r_state <= COLLECT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_buf <= w_line_next;
                        r_cnt <= r_cnt + 1'b1;
                        // Publish line and index together so they hold until the next write.
                        if (w_last) begin
                            r_wr_line  <= w_line_next;
                            r_wr_index <= r_index;
                            r_state    <= WRITE;
                        end
                    end
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_en    = (r_state == WRITE) ? r_sel : '0;
    assign o_done     = (r_state == WRITE);
    assign o_busy     = (r_state != IDLE);
    assign o_err      = r_err;
    assign o_wr_line  = r_wr_line;
    assign o_wr_index = r_wr_index;

endmodule
